// File: rtl/melody_sequencer_if.sv
// Song ROM bus: the sequencer (master) drives the address, the synchronous ROM (slave)
// returns the addressed word one clock later.
interface melody_sequencer_if;
    logic [6:0]  rom_addr;
    logic [12:0] rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/melody_sequencer.sv
// Melody sequencer: in auto mode it walks a song ROM and drives pitch/tone for each entry's
// duration, with optional silent gaps and looping; in manual mode the keys pass straight through.
// ROM word: [12:10] pitch, [9:3] one-hot tone, [2:0] duration-1 in ticks.
module melody_sequencer #(
    parameter int TICK_DIV = 250000,
    parameter int GAP_CYC  = 20000,
    parameter int LOOP     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               auto_sw,
    input  logic               start,
    input  logic [6:0]         key,
    input  logic [2:0]         SW,
    melody_sequencer_if.master rom,
    output logic [2:0]         pitch,
    output logic [6:0]         tone,
    output logic               busy,
    output logic               song_done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_PAUSE, S_GAP, S_DONE
    } state_t;

    state_t        state, state_n;
    logic [6:0]    addr_q, addr_n;
    logic [2:0]    pitch_n;
    logic [6:0]    tone_n;
    logic          done_n;
    logic [2:0]    cap_pitch, cap_pitch_n;
    logic [6:0]    cap_tone, cap_tone_n;
    logic [2:0]    cap_dur, cap_dur_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [2:0]    dur_cnt, dur_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic          expired_q, expired_n;
    logic          note_over;

    logic          ld_rest;
    logic          ld_end;
    logic [2:0]    ld_pitch;
    logic [6:0]    ld_tone;
    logic          tick_last;
    logic          play_end;

    // A multi-hot tone is played as a rest; pitch 111 (or a dead last address) ends the song.
    assign ld_rest   = !$onehot0(rom.rom_data[9:3]);
    assign ld_pitch  = ld_rest ? 3'd0 : rom.rom_data[12:10];
    assign ld_tone   = ld_rest ? 7'd0 : rom.rom_data[9:3];
    assign ld_end    = (rom.rom_data[12:10] == 3'b111) ||
                       ((addr_q == 7'd127) && !$onehot(rom.rom_data[9:3]));
    assign tick_last = (tick_cnt == TICK_LAST);
    assign play_end  = tick_last && (dur_cnt == cap_dur);

    assign rom.rom_addr = addr_q;
    assign busy         = (state != S_IDLE) && (state != S_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state plus next values of every datapath register; outputs follow the state being entered.
    always_comb begin
        state_n     = state;
        addr_n      = addr_q;
        pitch_n     = 3'd0;
        tone_n      = 7'd0;
        done_n      = 1'b0;
        cap_pitch_n = cap_pitch;
        cap_tone_n  = cap_tone;
        cap_dur_n   = cap_dur;
        tick_n      = tick_cnt;
        dur_n       = dur_cnt;
        gap_n       = gap_cnt;
        expired_n   = expired_q;
        note_over   = 1'b0;

        if (!auto_sw) begin
            state_n   = S_IDLE;
            pitch_n   = SW;
            tone_n    = key;
            tick_n    = '0;
            dur_n     = '0;
            gap_n     = '0;
            expired_n = 1'b0;
        end else if (start || (state == S_IDLE)) begin
            state_n   = S_FETCH;
            addr_n    = 7'd0;
            tick_n    = '0;
            dur_n     = '0;
            gap_n     = '0;
            expired_n = 1'b0;
        end else begin
            case (state)
                S_FETCH: state_n = S_LOAD;
                S_LOAD: begin
                    if (ld_end) begin
                        done_n = 1'b1;
                        if (LOOP != 0) begin
                            state_n = S_FETCH;
                            addr_n  = 7'd0;
                        end else begin
                            state_n = S_DONE;
                        end
                    end else begin
                        state_n     = S_PLAY;
                        cap_pitch_n = ld_pitch;
                        cap_tone_n  = ld_tone;
                        cap_dur_n   = rom.rom_data[2:0];
                        pitch_n     = ld_pitch;
                        tone_n      = ld_tone;
                        tick_n      = '0;
                        dur_n       = '0;
                        expired_n   = 1'b0;
                    end
                end
                S_PLAY: begin
                    if (tick_last) begin
                        tick_n = '0;
                        dur_n  = dur_cnt + 3'd1;
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                    if (key != 7'd0) begin
                        state_n   = S_PAUSE;
                        expired_n = play_end;
                        pitch_n   = SW;
                        tone_n    = key;
                    end else if (play_end) begin
                        note_over = 1'b1;
                    end else begin
                        pitch_n = cap_pitch;
                        tone_n  = cap_tone;
                    end
                end
                S_PAUSE: begin
                    if (key != 7'd0) begin
                        pitch_n = SW;
                        tone_n  = key;
                    end else if (expired_q) begin
                        note_over = 1'b1;
                    end else begin
                        state_n = S_PLAY;
                        pitch_n = cap_pitch;
                        tone_n  = cap_tone;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n = S_FETCH;
                        addr_n  = addr_q + 7'd1;
                    end else begin
                        gap_n = gap_cnt + GW'(1);
                    end
                end
                S_DONE:  state_n = S_DONE;
                default: state_n = S_IDLE;
            endcase

            if (note_over) begin
                expired_n = 1'b0;
                if (GAP_CYC > 0) begin
                    state_n = S_GAP;
                    gap_n   = '0;
                end else begin
                    state_n = S_FETCH;
                    addr_n  = addr_q + 7'd1;
                end
            end
        end
    end

    // Datapath registers: address, outputs, captured entry and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= 7'd0;
            pitch     <= 3'd0;
            tone      <= 7'd0;
            song_done <= 1'b0;
            cap_pitch <= 3'd0;
            cap_tone  <= 7'd0;
            cap_dur   <= 3'd0;
            tick_cnt  <= '0;
            dur_cnt   <= 3'd0;
            gap_cnt   <= '0;
            expired_q <= 1'b0;
        end else begin
            addr_q    <= addr_n;
            pitch     <= pitch_n;
            tone      <= tone_n;
            song_done <= done_n;
            cap_pitch <= cap_pitch_n;
            cap_tone  <= cap_tone_n;
            cap_dur   <= cap_dur_n;
            tick_cnt  <= tick_n;
            dur_cnt   <= dur_n;
            gap_cnt   <= gap_n;
            expired_q <= expired_n;
        end
    end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 250000, is the clk cycles per duration tick (4 Hz at 1 MHz).
REQ-002 Parameter GAP_CYC, default 20000, is the silent clk cycles between consecutive song entries; 0 disables the gap.
REQ-003 Parameter LOOP, default 0, means the song restarts at address 0 after the end marker when 1.
REQ-004 clk  input  1  system clock, 1 MHz; the only clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 auto_sw  input  1  level; 1 selects auto-play, 0 selects manual play.
REQ-007 start  input  1  one-cycle pulse; restarts the song from address 0.
REQ-008 key  input  7  manual note keys, one-hot, bit0 = note 1.
REQ-009 SW  input  3  manual register select: 001 high, 010 middle, 100 low.
REQ-010 rom_addr  output  7  registered song ROM address.
REQ-011 rom_data  input  13  synchronous ROM word: [12:10] pitch, [9:3] tone, [2:0] dur-1; the word is valid one cycle after rom_addr changes.
REQ-012 pitch  output  3  registered register select to the tone datapath.
REQ-013 tone  output  7  registered one-hot note to the tone datapath; 0 means silence.
REQ-014 busy  output  1  1 in every state except IDLE and DONE.
REQ-015 song_done  output  1  one-cycle pulse when the end of the song is reached.

Function
REQ-016 States: IDLE, FETCH, LOAD, PLAY, PAUSE, GAP, DONE.
REQ-017 IDLE: pitch<=SW and tone<=key every cycle, giving 1-cycle latency.
- IDLE->FETCH when auto_sw=1, with rom_addr<=0.
REQ-018 FETCH holds for 1 cycle, then goes to LOAD.
REQ-019 LOAD captures rom_data.
- If pitch field = 111 or the captured address is 127 with a non-playable entry, the entry is the end marker: pulse song_done, then FETCH with rom_addr<=0 if LOOP=1, else go to DONE.
- Otherwise go to PLAY.
REQ-020 PLAY drives the captured pitch and tone from its first cycle and lasts exactly (dur+1)*TICK_DIV cycles.
- The tick divider and duration counter clear on PLAY entry.
REQ-021 A captured tone that is neither zero nor one-hot is driven as tone=0 and pitch=0 (rest); the duration is still honoured.
REQ-022 At the end of PLAY:
- If GAP_CYC>0, go to GAP, which drives pitch=0 and tone=0 for GAP_CYC cycles, then go to FETCH.
- If GAP_CYC=0, go directly to FETCH.
- rom_addr increments on the FETCH entry and wraps 127->0.
REQ-023 FETCH, LOAD and DONE drive pitch=0 and tone=0.
REQ-024 PLAY->PAUSE when key!=0.
- In PAUSE, pitch<=SW and tone<=key (manual override).
- The tick and duration counters freeze.
- PAUSE->PLAY when key==0; counting resumes from the frozen values.
REQ-025 In any non-IDLE state, auto_sw=0 forces IDLE on the next edge.
- The sequence position is discarded.
- Manual passthrough begins that edge.
REQ-026 A start pulse with auto_sw=1 in any state goes to FETCH with rom_addr<=0 and clears all counters.
- start has priority over all other transitions except auto_sw=0.
- A start pulse with auto_sw=0 is ignored.
REQ-027 DONE stays silent until start, or until auto_sw falls and then rises again.
REQ-028 If the duration expiry and a key press occur in the same cycle, the sequencer enters PAUSE with zero remaining duration and moves to GAP or FETCH on key release.
REQ-029 song_done is asserted for exactly one cycle per end marker, including when looping.

Reset
REQ-030 While rst=1:
- state=IDLE.
- rom_addr=0, pitch=0, tone=0, busy=0, song_done=0.
- All counters are 0.
REQ-031 After rst deasserts, the first edge behaves as IDLE; a held auto_sw=1 starts the song.

Verification
REQ-032 TICK_DIV=4, GAP_CYC=2, LOOP=0, ROM[0]={010,0000001,001}, ROM[1]={111,0,0}; raise auto_sw -> mid-1 on pitch/tone for 8 cycles, then 2 silent cycles, then DONE, song_done pulses once, busy=0.
REQ-033 Same ROM with LOOP=1 -> song_done pulses every 14 cycles (FETCH+LOAD+8+2+FETCH+LOAD) and rom_addr cycles 0,1,0.
REQ-034 Press key=0000100, SW=001 for 5 cycles after 3 PLAY cycles -> tone=0000100 and pitch=001 during the press; the note then resumes for the remaining 5 cycles.
REQ-035 Drop auto_sw mid-PLAY -> next edge enters IDLE, pitch=SW, tone=key; re-raise -> restarts at rom_addr=0.
REQ-036 ROM entry tone=0000011 -> pitch=0 and tone=0 for the full duration; assert rst mid-PLAY -> all outputs 0 immediately, without waiting for a clk edge.
